l1_data_bank: RTL and testbench

- N-way, byte-enabled L1 data array with a built-in line-refill assembler.
- Parametrised in line size, set count, way count and refill beat width; this is the next-generation data store for the L1 cache.
- Core side: a read returns every way of the indexed set in parallel, so tag compare and way select stay in the cache controller. A write targets one way with per-byte enables.
- Refill side: the bus interface streams a line in beats; the block assembles the beats and commits the full line in a single array write.

---
 rtl/l1_data_bank_if.sv | 48 ++++
 rtl/l1_data_bank.sv | 194 +++++++++++++++++++
 tb/tb_l1_data_bank.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/l1_data_bank_if.sv
// Core and refill signal bundle for the L1 data bank.
// slave: the data bank itself; master: the cache controller / bus side.
interface l1_data_bank_if #(
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int BEAT_BYTES = 4
);
    localparam int DATA_W  = 8 * LINE_BYTES;
    localparam int IDX_W   = $clog2(SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEAT_DW = 8 * BEAT_BYTES;

    // core request port
    logic                     req_valid_i;
    logic                     req_ready_o;
    logic                     req_we_i;
    logic [WAY_W-1:0]         req_way_i;
    logic [IDX_W-1:0]         req_idx_i;
    logic [LINE_BYTES-1:0]    req_be_i;
    logic [DATA_W-1:0]        req_data_i;
    logic                     rd_valid_o;
    logic [WAYS*DATA_W-1:0]   rd_data_o;

    // refill port
    logic                     fill_start_i;
    logic [WAY_W-1:0]         fill_way_i;
    logic [IDX_W-1:0]         fill_idx_i;
    logic                     fill_beat_valid_i;
    logic                     fill_beat_ready_o;
    logic [BEAT_DW-1:0]       fill_beat_data_i;
    logic                     fill_busy_o;
    logic                     fill_done_o;

    modport slave (
        input  req_valid_i, req_we_i, req_way_i, req_idx_i, req_be_i, req_data_i,
        input  fill_start_i, fill_way_i, fill_idx_i, fill_beat_valid_i, fill_beat_data_i,
        output req_ready_o, rd_valid_o, rd_data_o,
        output fill_beat_ready_o, fill_busy_o, fill_done_o
    );

    modport master (
        output req_valid_i, req_we_i, req_way_i, req_idx_i, req_be_i, req_data_i,
        output fill_start_i, fill_way_i, fill_idx_i, fill_beat_valid_i, fill_beat_data_i,
        input  req_ready_o, rd_valid_o, rd_data_o,
        input  fill_beat_ready_o, fill_busy_o, fill_done_o
    );
endinterface

// File: rtl/l1_data_bank.sv
// N-way byte-enabled L1 data array with a line-refill assembler.
// A read returns all ways of the indexed set; writes hit one way with byte
// enables. Refill beats are collected into a line buffer and committed in one
// full-line write during the single COMMIT cycle, which blocks the core port.
// Optional build macro L1_DATA_BANK_OUT_REG_EN adds an output pipeline stage
// (read latency 2 instead of 1).
module l1_data_bank #(
    parameter int LINE_BYTES = 16,
    parameter int SETS       = 64,
    parameter int WAYS       = 2,
    parameter int BEAT_BYTES = 4
) (
    input logic           clk_i,
    input logic           rst_i,
    l1_data_bank_if.slave bus
);
    localparam int DATA_W  = 8 * LINE_BYTES;
    localparam int IDX_W   = $clog2(SETS);
    localparam int WAY_W   = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEATS   = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_DW = 8 * BEAT_BYTES;
    localparam int CNT_W   = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int RD_W    = WAYS * DATA_W;

    typedef enum logic [1:0] {IDLE, FILL, COMMIT} state_t;

    state_t              state_reg, state_next;
    logic [CNT_W-1:0]    beat_cnt_reg, beat_cnt_next;
    logic [WAY_W-1:0]    fill_way_reg;
    logic [IDX_W-1:0]    fill_idx_reg;
    logic [DATA_W-1:0]   line_reg;
    logic                done_reg;
    logic                start_fire;
    logic                beat_fire;

    logic                req_ready;
    logic                rd_fire;
    logic                wr_en;
    logic [WAY_W-1:0]    wr_way;
    logic [IDX_W-1:0]    wr_idx;
    logic [LINE_BYTES-1:0] wr_be;
    logic [DATA_W-1:0]   wr_data;

    logic                rd_valid_reg;
    logic [RD_W-1:0]     rd_data_int;

    // Refill FSM state, beat counter and latched target
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg    <= IDLE;
            beat_cnt_reg <= '0;
            fill_way_reg <= '0;
            fill_idx_reg <= '0;
            done_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            beat_cnt_reg <= beat_cnt_next;
            done_reg     <= (state_reg == COMMIT);
            if (start_fire) begin
                fill_way_reg <= bus.fill_way_i;
                fill_idx_reg <= bus.fill_idx_i;
            end
        end
    end

    // Refill next-state logic: start only from IDLE, beats only in FILL
    always_comb begin
        state_next    = state_reg;
        beat_cnt_next = beat_cnt_reg;
        start_fire    = 1'b0;
        beat_fire     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (bus.fill_start_i) begin
                    start_fire    = 1'b1;
                    state_next    = FILL;
                    beat_cnt_next = '0;
                end
            end
            FILL: begin
                if (bus.fill_beat_valid_i) begin
                    beat_fire = 1'b1;
                    if (beat_cnt_reg == CNT_W'(BEATS - 1)) begin
                        state_next = COMMIT;
                    end else begin
                        beat_cnt_next = beat_cnt_reg + 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Line assembly: beat k lands in bytes [k*BEAT_BYTES +: BEAT_BYTES]
    always_ff @(posedge clk_i) begin
        if (beat_fire) begin
            for (int k = 0; k < BEATS; k++) begin
                if (beat_cnt_reg == CNT_W'(k)) begin
                    line_reg[k*BEAT_DW +: BEAT_DW] <= bus.fill_beat_data_i;
                end
            end
        end
    end

    // Single array write port: the commit owns it in COMMIT, the core otherwise
    always_comb begin
        req_ready = (state_reg != COMMIT);
        rd_fire   = bus.req_valid_i && req_ready && !bus.req_we_i;
        wr_en     = 1'b0;
        wr_way    = bus.req_way_i;
        wr_idx    = bus.req_idx_i;
        wr_be     = bus.req_be_i;
        wr_data   = bus.req_data_i;
        if (state_reg == COMMIT) begin
            wr_en   = 1'b1;
            wr_way  = fill_way_reg;
            wr_idx  = fill_idx_reg;
            wr_be   = '1;
            wr_data = line_reg;
        end else if (bus.req_valid_i && bus.req_we_i) begin
            wr_en = 1'b1;
        end
    end

    for (genvar gi = 0; gi < WAYS; gi++) begin : g_way
        logic [DATA_W-1:0] mem [SETS];
        logic [DATA_W-1:0] rd_way_reg;

        // Byte-enabled write into this way
        always_ff @(posedge clk_i) begin
            if (wr_en && (wr_way == WAY_W'(gi))) begin
                for (int b = 0; b < LINE_BYTES; b++) begin
                    if (wr_be[b]) begin
                        mem[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
                    end
                end
            end
        end

        // Registered read; holds until the next read is accepted
        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_way_reg <= '0;
            end else if (rd_fire) begin
                rd_way_reg <= mem[bus.req_idx_i];
            end
        end

        assign rd_data_int[gi*DATA_W +: DATA_W] = rd_way_reg;
    end

    // Read-valid flag matching the read register stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_reg <= 1'b0;
        end else begin
            rd_valid_reg <= rd_fire;
        end
    end

`ifdef L1_DATA_BANK_OUT_REG_EN
    logic            rd_valid_out_reg;
    logic [RD_W-1:0] rd_data_out_reg;

    // Extra output pipeline stage
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_valid_out_reg <= 1'b0;
            rd_data_out_reg  <= '0;
        end else begin
            rd_valid_out_reg <= rd_valid_reg;
            if (rd_valid_reg) begin
                rd_data_out_reg <= rd_data_int;
            end
        end
    end

    assign bus.rd_valid_o = rd_valid_out_reg;
    assign bus.rd_data_o  = rd_data_out_reg;
`else
    assign bus.rd_valid_o = rd_valid_reg;
    assign bus.rd_data_o  = rd_data_int;
`endif

    assign bus.req_ready_o       = req_ready;
    assign bus.fill_beat_ready_o = (state_reg == FILL);
    assign bus.fill_busy_o       = (state_reg != IDLE);
    assign bus.fill_done_o       = done_reg;
endmodule

// File: tb/tb_l1_data_bank.sv
// Scoreboard bench for l1_data_bank: a line-level memory model plus a refill
// phase tracker predict every cycle; reads are queued and checked by a monitor.
module tb_l1_data_bank;
    localparam int LINE_BYTES = 16;
    localparam int SETS       = 64;
    localparam int WAYS       = 2;
    localparam int BEAT_BYTES = 4;
    localparam int DATA_W     = 8 * LINE_BYTES;
    localparam int IDX_W      = $clog2(SETS);
    localparam int WAY_W      = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int BEATS      = LINE_BYTES / BEAT_BYTES;
    localparam int BEAT_DW    = 8 * BEAT_BYTES;
    localparam int RD_W       = WAYS * DATA_W;
`ifdef L1_DATA_BANK_OUT_REG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    l1_data_bank_if #(.LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS), .BEAT_BYTES(BEAT_BYTES)) bus ();

    l1_data_bank #(.LINE_BYTES(LINE_BYTES), .SETS(SETS), .WAYS(WAYS), .BEAT_BYTES(BEAT_BYTES)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [RD_W-1:0] data;
        int              due;
    } rd_exp_t;

    rd_exp_t          sb[$];
    logic [DATA_W-1:0] mm [WAYS][SETS];
    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // refill model: 0 = no refill, 1 = collecting beats, 2 = line being written
    int               phase = 0;
    int               f_beats = 0;
    logic [WAY_W-1:0] f_way;
    logic [IDX_W-1:0] f_idx;
    logic [DATA_W-1:0] f_line;
    bit               done_now = 1'b0;

    // stimulus for the next cycle
    bit                    s_valid, s_we, s_start, s_bvalid, s_rst;
    logic [WAY_W-1:0]      s_way, s_fway;
    logic [IDX_W-1:0]      s_idx, s_fidx;
    logic [LINE_BYTES-1:0] s_be;
    logic [DATA_W-1:0]     s_data;
    logic [BEAT_DW-1:0]    s_bdata;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [RD_W-1:0] act, input logic [RD_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] rnd_line();
        logic [DATA_W-1:0] v;
        for (int i = 0; i < DATA_W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic idle_stim();
        s_valid = 0; s_we = 0; s_start = 0; s_bvalid = 0; s_rst = 0;
        s_way = '0; s_idx = '0; s_be = '0; s_data = '0;
        s_fway = '0; s_fidx = '0; s_bdata = '0;
    endtask

    // One clock: check current outputs against the model, drive, advance model
    task automatic do_cycle();
        logic [RD_W-1:0] e;
        bit core_ok;
        @(negedge clk);
        chk("req_ready", RD_W'(bus.req_ready_o), RD_W'(phase != 2));
        chk("fill_busy", RD_W'(bus.fill_busy_o), RD_W'(phase != 0));
        chk("beat_ready", RD_W'(bus.fill_beat_ready_o), RD_W'(phase == 1));
        chk("fill_done", RD_W'(bus.fill_done_o), RD_W'(done_now));
        if (rst) begin
            chk("rst_rd_valid", RD_W'(bus.rd_valid_o), '0);
            chk("rst_rd_data", bus.rd_data_o, '0);
        end
        rst                   = s_rst;
        bus.req_valid_i       = s_valid;
        bus.req_we_i          = s_we;
        bus.req_way_i         = s_way;
        bus.req_idx_i         = s_idx;
        bus.req_be_i          = s_be;
        bus.req_data_i        = s_data;
        bus.fill_start_i      = s_start;
        bus.fill_way_i        = s_fway;
        bus.fill_idx_i        = s_fidx;
        bus.fill_beat_valid_i = s_bvalid;
        bus.fill_beat_data_i  = s_bdata;
        if (s_rst) begin
            phase    = 0;
            f_beats  = 0;
            done_now = 0;
            sb.delete();
        end else begin
            core_ok  = (phase != 2);
            done_now = (phase == 2);
            if (phase == 2) begin
                mm[f_way][f_idx] = f_line;
                phase = 0;
            end else if (phase == 1) begin
                if (s_bvalid) begin
                    f_line[f_beats*BEAT_DW +: BEAT_DW] = s_bdata;
                    f_beats++;
                    if (f_beats == BEATS) phase = 2;
                end
            end else if (s_start) begin
                phase   = 1;
                f_way   = s_fway;
                f_idx   = s_fidx;
                f_beats = 0;
            end
            if (s_valid && core_ok) begin
                if (s_we) begin
                    for (int b = 0; b < LINE_BYTES; b++)
                        if (s_be[b]) mm[s_way][s_idx][b*8 +: 8] = s_data[b*8 +: 8];
                end else begin
                    for (int w = 0; w < WAYS; w++) e[w*DATA_W +: DATA_W] = mm[w][s_idx];
                    sb.push_back('{data: e, due: cyc + LAT});
                end
            end
        end
    endtask

    task automatic wr(input int way, input int idx, input logic [LINE_BYTES-1:0] be, input logic [DATA_W-1:0] data);
        idle_stim();
        s_valid = 1; s_we = 1;
        s_way = WAY_W'(way); s_idx = IDX_W'(idx); s_be = be; s_data = data;
        do_cycle();
    endtask

    task automatic rd(input int idx);
        idle_stim();
        s_valid = 1; s_idx = IDX_W'(idx);
        do_cycle();
    endtask

    task automatic start(input int way, input int idx, input bit with_beat);
        idle_stim();
        s_start = 1; s_fway = WAY_W'(way); s_fidx = IDX_W'(idx);
        s_bvalid = with_beat; s_bdata = $urandom;
        do_cycle();
    endtask

    task automatic beat(input logic [BEAT_DW-1:0] d);
        idle_stim();
        s_bvalid = 1; s_bdata = d;
        do_cycle();
    endtask

    task automatic idle(input int n);
        idle_stim();
        repeat (n) do_cycle();
    endtask

    // Monitor: every returned read must match the oldest expectation, on time
    initial begin
        rd_exp_t x;
        forever begin
            @(negedge clk);
            if (bus.rd_valid_o === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_spurious at cycle %0d: rd_valid_o=1 expected no read outstanding", cyc);
                end else begin
                    x = sb.pop_front();
                    chk("rd_data", bus.rd_data_o, x.data);
                    chk("rd_latency", RD_W'(cyc), RD_W'(x.due));
                    $display("read returned cycle %0d data %h", cyc, bus.rd_data_o);
                end
            end else if (sb.size() > 0 && sb[0].due <= cyc) begin
                x = sb.pop_front();
                checks++;
                errors++;
                $display("FAIL rd_missing at cycle %0d: rd_valid_o=0 expected read due at cycle %0d", cyc, x.due);
            end
        end
    end

    initial begin
        idle_stim();
        s_rst = 1;
        repeat (3) do_cycle();
        idle_stim();

        // give every line a known value
        for (int w = 0; w < WAYS; w++)
            for (int i = 0; i < SETS; i++)
                wr(w, i, '1, rnd_line());

        // read after write
        wr(1, 5, '1, 128'h00112233_44556677_8899AABB_CCDDEEFF);
        rd(5);
        idle(2);

        // byte merge and a zero-enable no-op
        wr(0, 3, '1, {LINE_BYTES{8'hAA}});
        wr(0, 3, 16'h0001, 128'h55);
        wr(0, 3, 16'h0000, rnd_line());
        rd(3);
        idle(2);

        // refill with a gap; a beat alongside the start is not taken
        start(0, 10, 1'b1);
        beat(32'h03020100);
        beat(32'h07060504);
        idle(1);
        beat(32'h0B0A0908);
        beat(32'h0F0E0D0C);
        idle(1);
        rd(10);
        idle(3);

        // reset mid-fill: the partial line must never land
        start(1, 7, 1'b0);
        beat($urandom);
        beat($urandom);
        idle_stim();
        s_rst = 1;
        do_cycle();
        idle(3);
        rd(7);
        idle(2);

        // core write during FILL, then the commit overwrites it
        start(1, 20, 1'b0);
        beat($urandom);
        wr(1, 20, '1, rnd_line());
        rd(20);
        beat($urandom);
        beat($urandom);
        beat($urandom);
        idle(1);
        rd(20);
        idle(2);

        // redundant start during FILL is ignored
        start(0, 30, 1'b0);
        beat($urandom);
        idle_stim();
        s_start = 1; s_fway = 1; s_fidx = 31; s_bvalid = 1; s_bdata = $urandom;
        do_cycle();
        beat($urandom);
        beat($urandom);
        start(1, 31, 1'b0);
        rd(30);
        rd(31);
        idle(8);

        // randomized traffic on a small set window to force collisions
        for (int n = 0; n < 1500; n++) begin
            idle_stim();
            s_valid  = ($urandom_range(0, 3) != 0);
            s_we     = $urandom_range(0, 1) == 1;
            s_way    = WAY_W'($urandom_range(0, WAYS - 1));
            s_idx    = IDX_W'($urandom_range(0, 7));
            s_be     = ($urandom_range(0, 7) == 0) ? '0 : LINE_BYTES'($urandom);
            s_data   = rnd_line();
            s_start  = ($urandom_range(0, 7) == 0);
            s_fway   = WAY_W'($urandom_range(0, WAYS - 1));
            s_fidx   = IDX_W'($urandom_range(0, 7));
            s_bvalid = $urandom_range(0, 1) == 1;
            s_bdata  = $urandom;
            do_cycle();
        end

        idle(LAT + 4);
        chk("reads_drained", RD_W'(sb.size()), '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
